// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg : shared types and defaults for the DFT result unload path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  localparam int c_ADDR_W_DEFAULT = 12;
  localparam int c_DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } rd_state_e;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } fft_word_t;

endpackage

`default_nettype wire

// File: rtl/fft_out_fifo2.sv
// ---------------------------------------------------------------------------
// fft_out_fifo2 : 2-entry output FIFO with data+last payload, registered head
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_out_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic [1:0]        occupancy_o,
  output logic              head_valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o
);

  logic              head_vld_q;
  logic [DATA_W-1:0] head_data_q;
  logic              head_last_q;
  logic              tail_vld_q;
  logic [DATA_W-1:0] tail_data_q;
  logic              tail_last_q;
  logic              w_pop;

  assign w_pop = pop_i & head_vld_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_vld_q  <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else if (ce_i) begin
      if (w_pop) begin
        // Tail always refills the head first so ordering is preserved.
        if (tail_vld_q) begin
          head_data_q <= tail_data_q;
          head_last_q <= tail_last_q;
          if (push_i) begin
            tail_data_q <= push_data_i;
            tail_last_q <= push_last_i;
          end else begin
            tail_vld_q <= 1'b0;
          end
        end else if (push_i) begin
          head_data_q <= push_data_i;
          head_last_q <= push_last_i;
        end else begin
          head_vld_q <= 1'b0;
        end
      end else if (push_i) begin
        if (!head_vld_q) begin
          head_vld_q  <= 1'b1;
          head_data_q <= push_data_i;
          head_last_q <= push_last_i;
        end else begin
          tail_vld_q  <= 1'b1;
          tail_data_q <= push_data_i;
          tail_last_q <= push_last_i;
        end
      end
    end
  end

  assign occupancy_o  = tail_vld_q ? 2'd2 : (head_vld_q ? 2'd1 : 2'd0);
  assign head_valid_o = head_vld_q;
  assign head_data_o  = head_data_q;
  assign head_last_o  = head_last_q;

endmodule

`default_nettype wire

// File: rtl/fft_result_reader.sv
// ---------------------------------------------------------------------------
// fft_result_reader : streams N result bins from a 1-cycle-latency RAM out on
// a valid/ready interface, pulsing unload_done after the last accepted bin.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_result_reader
  import fft_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DEFAULT,
  parameter int DATA_W = c_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] sample_num,
  input  logic              calc_end,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              unload_done,
  output logic [1:0]        state
);

  rd_state_e         state_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] beat_cnt_q;
  logic              infl_q;
  logic              infl_last_q;

  logic [1:0]        w_occ;
  logic              w_pop;
  logic [2:0]        w_level;
  logic              w_ptr_is_last;
  logic              w_beat_is_last;

  assign w_pop          = m_valid & m_ready;
  assign w_ptr_is_last  = (rd_ptr_q == n_q - ADDR_W'(1));
  assign w_beat_is_last = (beat_cnt_q == n_q - ADDR_W'(1));

  // A beat leaving this cycle frees its slot, keeping 1 bin/cycle under ready=1.
  assign w_level   = 3'(w_occ) + 3'(infl_q) - 3'(w_pop);
  assign ram_rd_en = (state_q == ST_READ) && (w_level < 3'd2);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      rd_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else if (ce) begin
      infl_q      <= ram_rd_en;
      infl_last_q <= ram_rd_en & w_ptr_is_last;
      case (state_q)
        ST_IDLE: begin
          if (calc_end) begin
            n_q        <= sample_num;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            state_q    <= (sample_num == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (ram_rd_en) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            if (w_ptr_is_last) state_q <= ST_DRAIN;
          end
          if (w_pop) beat_cnt_q <= beat_cnt_q + ADDR_W'(1);
        end
        ST_DRAIN: begin
          if (w_pop) begin
            beat_cnt_q <= beat_cnt_q + ADDR_W'(1);
            if (w_beat_is_last) state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fft_out_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .nrst         (nrst),
    .ce_i         (ce),
    .push_i       (infl_q),
    .push_data_i  (ram_rd_data),
    .push_last_i  (infl_last_q),
    .pop_i        (m_ready),
    .occupancy_o  (w_occ),
    .head_valid_o (m_valid),
    .head_data_o  (m_data),
    .head_last_o  (m_last)
  );

  assign ram_rd_addr = rd_ptr_q;
  assign busy        = (state_q != ST_IDLE);
  assign unload_done = (state_q == ST_DONE);
  assign state       = state_q;

endmodule

`default_nettype wire
